// File: rtl/rom_upload_reader_if.sv
// rom_upload_reader_if
//   Toggle-handshake read port between the upload reader (master) and the
//   sdram controller (slave).
//   mem_req  master->slave  toggles once per read request
//   mem_a    master->slave  word address, held while the request is open
//   mem_ack  slave->master  toggles back; transaction done when equal to mem_req
//   mem_q    slave->master  read word, valid when mem_ack becomes equal to mem_req
interface rom_upload_reader_if #(
  parameter int AW = 23
);
  logic          mem_req;
  logic          mem_ack;
  logic [AW-1:0] mem_a;
  logic [15:0]   mem_q;

  modport master (output mem_req, output mem_a, input mem_ack, input mem_q);
  modport slave  (input mem_req, input mem_a, output mem_ack, output mem_q);
endinterface

// File: rtl/rom_upload_reader.sv
// rom_upload_reader
//   Serves byte reads from the data_io upload side by fetching 16-bit words
//   over the sdram toggle-handshake port. A one-word cache lets both bytes of
//   a word share a single sdram access, so the host can dump ROM/NVRAM back.
//
// Ports
//   clk_sys       system clock (sdram controller domain)
//   reset_n       asynchronous active-low reset
//   ioctl_upload  upload session active
//   ioctl_rd      one-cycle strobe requesting the byte at ioctl_addr
//   ioctl_addr    byte address (AW+1 bits), sampled with ioctl_rd
//   ioctl_din     requested byte, valid once busy is low after a strobe
//   busy          high while a requested byte is not yet available
//   mem           sdram read port (master side of rom_upload_reader_if)
//
// Parameters
//   AW    sdram word address width
//   BASE  word offset added to the host word address (wraps mod 2^AW)
//
// Build option
//   ROM_UPLOAD_PREFETCH_EN  when defined, fetch word tag+1 after a byte with
//                           addr[0]=1 is served, so sequential dumps hit.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// S_IDLE   | no transaction open; serves strobes and the pending slot
// S_FETCH  | demand read open; busy high until it completes
// S_DRAIN  | session ended with a read open; wait for ack, discard data
// S_PREFETCH | speculative read of tag+1 open; busy low unless a strobe waits
module rom_upload_reader #(
  parameter int            AW   = 23,
  parameter logic [AW-1:0] BASE = '0
) (
  input  logic                 clk_sys,
  input  logic                 reset_n,
  input  logic                 ioctl_upload,
  input  logic                 ioctl_rd,
  input  logic [AW:0]          ioctl_addr,
  output logic [7:0]           ioctl_din,
  output logic                 busy,
  rom_upload_reader_if.master  mem
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_PREFETCH} state_t;

  state_t        state;
  logic          upload_q;
  logic          mem_req_r;
  logic [AW-1:0] mem_a_r;
  logic [AW-1:0] cache_tag;
  logic [15:0]   cache_data;
  logic          cache_vld;
  logic          pend_vld;
  logic [AW:0]   pend_addr;
  logic [AW:0]   cur_addr;
`ifdef ROM_UPLOAD_PREFETCH_EN
  localparam logic [AW-1:0] ONE = {{(AW-1){1'b0}}, 1'b1};
  logic [AW-1:0] pf_word;
  logic          pf_due;
  logic [AW-1:0] pf_next;
`endif

  logic          mem_idle;
  logic          up_fall;
  logic          up_rise;
  logic          rd_ok;
  logic          req_vld;
  logic [AW:0]   req_addr;
  logic [AW-1:0] req_word;
  logic          req_hit;
  logic [7:0]    hit_byte;
  logic [7:0]    fetch_byte;

  assign mem.mem_req = mem_req_r;
  assign mem.mem_a   = mem_a_r;

  assign mem_idle   = (mem.mem_ack == mem_req_r);
  assign up_fall    = upload_q & ~ioctl_upload;
  assign up_rise    = ~upload_q & ioctl_upload;
  assign rd_ok      = ioctl_rd & ioctl_upload;
  // A fresh strobe supersedes whatever sits in the pending slot.
  assign req_vld    = rd_ok | pend_vld;
  assign req_addr   = rd_ok ? ioctl_addr : pend_addr;
  assign req_word   = req_addr[AW:1];
  // The cache is being invalidated on a session start, so it cannot hit then.
  assign req_hit    = cache_vld & ~up_rise & (req_word == cache_tag);
  assign hit_byte   = req_addr[0] ? cache_data[15:8] : cache_data[7:0];
  assign fetch_byte = cur_addr[0] ? mem.mem_q[15:8] : mem.mem_q[7:0];
`ifdef ROM_UPLOAD_PREFETCH_EN
  assign pf_next    = cache_tag + ONE;
`endif

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      upload_q   <= 1'b0;
      ioctl_din  <= '0;
      busy       <= 1'b0;
      mem_req_r  <= 1'b0;
      mem_a_r    <= '0;
      cache_tag  <= '0;
      cache_data <= '0;
      cache_vld  <= 1'b0;
      pend_vld   <= 1'b0;
      pend_addr  <= '0;
      cur_addr   <= '0;
`ifdef ROM_UPLOAD_PREFETCH_EN
      pf_word    <= '0;
      pf_due     <= 1'b0;
`endif
    end else begin
      upload_q <= ioctl_upload;
      if (up_fall) begin
        cache_vld <= 1'b0;
        pend_vld  <= 1'b0;
`ifdef ROM_UPLOAD_PREFETCH_EN
        pf_due    <= 1'b0;
`endif
        // Never abandon an open handshake: the next request must wait for ack.
        if (!mem_idle) begin
          state <= S_DRAIN;
          busy  <= 1'b1;
        end else begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      end else begin
        if (up_rise) cache_vld <= 1'b0;
        case (state)
          S_IDLE: begin
            if (req_vld) begin
              pend_vld <= 1'b0;
`ifdef ROM_UPLOAD_PREFETCH_EN
              pf_due   <= 1'b0;
`endif
              if (req_hit) begin
                ioctl_din <= hit_byte;
                busy      <= 1'b0;
`ifdef ROM_UPLOAD_PREFETCH_EN
                if (req_addr[0] & ioctl_upload) begin
                  pf_word   <= pf_next;
                  mem_a_r   <= pf_next + BASE;
                  mem_req_r <= ~mem_req_r;
                  state     <= S_PREFETCH;
                end
`endif
              end else begin
                cur_addr  <= req_addr;
                mem_a_r   <= req_word + BASE;
                mem_req_r <= ~mem_req_r;
                busy      <= 1'b1;
                state     <= S_FETCH;
              end
            end
`ifdef ROM_UPLOAD_PREFETCH_EN
            else if (pf_due & ioctl_upload) begin
              pf_due    <= 1'b0;
              pf_word   <= pf_next;
              mem_a_r   <= pf_next + BASE;
              mem_req_r <= ~mem_req_r;
              state     <= S_PREFETCH;
            end
`endif
          end

          S_FETCH: begin
            if (rd_ok) begin
              pend_vld  <= 1'b1;
              pend_addr <= ioctl_addr;
            end
            if (mem_idle) begin
              cache_tag  <= cur_addr[AW:1];
              cache_data <= mem.mem_q;
              cache_vld  <= 1'b1;
              ioctl_din  <= fetch_byte;
              // A queued request keeps busy high until IDLE services it.
              busy       <= rd_ok | pend_vld;
              state      <= S_IDLE;
`ifdef ROM_UPLOAD_PREFETCH_EN
              pf_due     <= cur_addr[0] & ~(rd_ok | pend_vld);
`endif
            end
          end

`ifdef ROM_UPLOAD_PREFETCH_EN
          S_PREFETCH: begin
            if (mem_idle) begin
              cache_tag  <= pf_word;
              cache_data <= mem.mem_q;
              cache_vld  <= 1'b1;
              state      <= S_IDLE;
              if (req_vld) begin
                if (req_word == pf_word) begin
                  // Serve straight from the arriving word.
                  ioctl_din <= req_addr[0] ? mem.mem_q[15:8] : mem.mem_q[7:0];
                  busy      <= 1'b0;
                  pend_vld  <= 1'b0;
                  pf_due    <= req_addr[0];
                end else begin
                  pend_vld  <= 1'b1;
                  pend_addr <= req_addr;
                  busy      <= 1'b1;
                end
              end
            end else if (rd_ok) begin
              pend_vld  <= 1'b1;
              pend_addr <= ioctl_addr;
              busy      <= 1'b1;
            end
          end
`endif

          S_DRAIN: begin
            if (rd_ok) begin
              pend_vld  <= 1'b1;
              pend_addr <= ioctl_addr;
            end
            if (mem_idle) begin
              busy  <= rd_ok | pend_vld;
              state <= S_IDLE;
            end
          end

          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rom_upload_reader.sv
module tb_rom_upload_reader;
  localparam int AW = 23;
`ifdef ROM_UPLOAD_PREFETCH_EN
  localparam int PF = 1;
`else
  localparam int PF = 0;
`endif

  logic          clk_sys = 1'b0;
  logic          reset_n;
  logic          ioctl_upload;
  logic          ioctl_rd;
  logic [AW:0]   ioctl_addr;
  logic [7:0]    din_a, din_b, din_c;
  logic          busy_a, busy_b, busy_c;

  int n_cmp = 0;
  int n_bad = 0;
  int lat   = 2;
  int cnt   = 0;
  int toggles = 0;
  logic req_d;

  rom_upload_reader_if #(.AW(AW)) m_if ();
  rom_upload_reader_if #(.AW(AW)) b_if ();
  rom_upload_reader_if #(.AW(AW)) c_if ();

  rom_upload_reader #(.AW(AW), .BASE(23'h0)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_upload(ioctl_upload),
    .ioctl_rd(ioctl_rd), .ioctl_addr(ioctl_addr), .ioctl_din(din_a),
    .busy(busy_a), .mem(m_if));
  rom_upload_reader #(.AW(AW), .BASE(23'h7000)) dut_b (
    .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_upload(ioctl_upload),
    .ioctl_rd(ioctl_rd), .ioctl_addr(ioctl_addr), .ioctl_din(din_b),
    .busy(busy_b), .mem(b_if));
  rom_upload_reader #(.AW(AW), .BASE(23'h1)) dut_c (
    .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_upload(ioctl_upload),
    .ioctl_rd(ioctl_rd), .ioctl_addr(ioctl_addr), .ioctl_din(din_c),
    .busy(busy_c), .mem(c_if));

  always #5 clk_sys = ~clk_sys;

  function automatic logic [15:0] mem_word(input logic [AW-1:0] a);
    if (a == 23'h8) return 16'hBEEF;
    return {~a[7:0], a[7:0]};
  endfunction

  // Main sdram model: acks after 'lat' cycles.
  always @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      m_if.mem_ack <= 1'b0;
      m_if.mem_q   <= '0;
      cnt          <= 0;
    end else if (m_if.mem_req != m_if.mem_ack) begin
      if (cnt + 1 >= lat) begin
        m_if.mem_ack <= m_if.mem_req;
        m_if.mem_q   <= mem_word(m_if.mem_a);
        cnt          <= 0;
      end else begin
        cnt <= cnt + 1;
      end
    end
  end

  // Address-only instances: ack on the next cycle.
  always @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      b_if.mem_ack <= 1'b0; b_if.mem_q <= '0;
      c_if.mem_ack <= 1'b0; c_if.mem_q <= '0;
    end else begin
      b_if.mem_ack <= b_if.mem_req; b_if.mem_q <= 16'h5AA5;
      c_if.mem_ack <= c_if.mem_req; c_if.mem_q <= 16'hA55A;
    end
  end

  always @(negedge clk_sys) begin
    if (m_if.mem_req !== req_d) toggles++;
    req_d = m_if.mem_req;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_sys); #1;
    end
  endtask

  task automatic strobe(input logic [AW:0] a);
    ioctl_rd = 1'b1; ioctl_addr = a;
    @(posedge clk_sys); #1;
    ioctl_rd = 1'b0;
  endtask

  task automatic wait_not_busy(input int max, output int cyc);
    cyc = 0;
    while (busy_a && cyc < max) begin
      tick(1); cyc++;
    end
  endtask

  task automatic test_reset();
    n_cmp++; if (din_a !== 8'h00) begin n_bad++; $display("FAIL rst_din: got %h want 00", din_a); end
    n_cmp++; if (busy_a !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy_a); end
    n_cmp++; if (m_if.mem_req !== 1'b0) begin n_bad++; $display("FAIL rst_req: got %b want 0", m_if.mem_req); end
    n_cmp++; if (m_if.mem_a !== 23'h0) begin n_bad++; $display("FAIL rst_mem_a: got %h want 0", m_if.mem_a); end
    n_cmp++; if ({din_b, din_c, busy_b, busy_c} !== 18'h0) begin n_bad++; $display("FAIL rst_others: got %h want 0", {din_b, din_c, busy_b, busy_c}); end
    n_cmp++; if ({b_if.mem_a, c_if.mem_a} !== 46'h0) begin n_bad++; $display("FAIL rst_others_a: got %h want 0", {b_if.mem_a, c_if.mem_a}); end
  endtask

  task automatic test_miss_hit();
    int t0, cyc;
    lat = 5; t0 = toggles;
    strobe(24'h000010);
    n_cmp++; if (m_if.mem_a !== 23'h8) begin n_bad++; $display("FAIL miss_mem_a: got %h want 8", m_if.mem_a); end
    n_cmp++; if (busy_a !== 1'b1) begin n_bad++; $display("FAIL miss_busy: got %b want 1", busy_a); end
    n_cmp++; if (b_if.mem_a !== 23'h7008) begin n_bad++; $display("FAIL base_b_a: got %h want 7008", b_if.mem_a); end
    n_cmp++; if (c_if.mem_a !== 23'h9) begin n_bad++; $display("FAIL base_c_a: got %h want 9", c_if.mem_a); end
    wait_not_busy(40, cyc);
    n_cmp++; if (cyc !== 6) begin n_bad++; $display("FAIL miss_latency: got %0d want 6", cyc); end
    n_cmp++; if (din_a !== 8'hEF) begin n_bad++; $display("FAIL miss_din: got %h want ef", din_a); end
    n_cmp++; if (toggles - t0 !== 1) begin n_bad++; $display("FAIL miss_toggles: got %0d want 1", toggles - t0); end
    t0 = toggles;
    strobe(24'h000011);
    n_cmp++; if (din_a !== 8'hBE) begin n_bad++; $display("FAIL hit_din: got %h want be", din_a); end
    n_cmp++; if (busy_a !== 1'b0) begin n_bad++; $display("FAIL hit_busy: got %b want 0", busy_a); end
    tick(1);
    n_cmp++; if (toggles - t0 !== PF) begin n_bad++; $display("FAIL hit_toggles: got %0d want %0d", toggles - t0, PF); end
    tick(12);
  endtask

  task automatic test_base_wrap();
    lat = 2;
    strobe(24'h000002);
    n_cmp++; if (b_if.mem_a !== 23'h7001) begin n_bad++; $display("FAIL base_7000: got %h want 7001", b_if.mem_a); end
    n_cmp++; if (c_if.mem_a !== 23'h2) begin n_bad++; $display("FAIL base_1: got %h want 2", c_if.mem_a); end
    tick(8);
    strobe(24'hFFFFFF);
    n_cmp++; if (c_if.mem_a !== 23'h0) begin n_bad++; $display("FAIL wrap_c: got %h want 0", c_if.mem_a); end
    n_cmp++; if (b_if.mem_a !== 23'h6FFF) begin n_bad++; $display("FAIL wrap_b: got %h want 6fff", b_if.mem_a); end
    n_cmp++; if (m_if.mem_a !== 23'h7FFFFF) begin n_bad++; $display("FAIL wrap_main: got %h want 7fffff", m_if.mem_a); end
    tick(10);
  endtask

  task automatic test_back_to_back();
    int t0, n, lows, cyc;
    lat = 5; t0 = toggles; lows = 0; n = 0;
    strobe(24'h000020);
    tick(1);
    strobe(24'h000040);
    n_cmp++; if (busy_a !== 1'b1) begin n_bad++; $display("FAIL b2b_busy: got %b want 1", busy_a); end
    while (m_if.mem_ack !== m_if.mem_req && n < 40) begin
      tick(1); n++;
      if (!busy_a) lows++;
    end
    n_cmp++; if (toggles - t0 !== 1) begin n_bad++; $display("FAIL b2b_first_ack: got %0d toggles want 1", toggles - t0); end
    tick(1);
    n_cmp++; if (busy_a !== 1'b1) begin n_bad++; $display("FAIL b2b_busy_held: got %b want 1", busy_a); end
    wait_not_busy(40, cyc);
    n_cmp++; if (busy_a !== 1'b0) begin n_bad++; $display("FAIL b2b_done: got %b want 0", busy_a); end
    n_cmp++; if (din_a !== 8'h20) begin n_bad++; $display("FAIL b2b_din: got %h want 20", din_a); end
    n_cmp++; if (m_if.mem_a !== 23'h20) begin n_bad++; $display("FAIL b2b_mem_a: got %h want 20", m_if.mem_a); end
    n_cmp++; if (toggles - t0 !== 2) begin n_bad++; $display("FAIL b2b_toggles: got %0d want 2", toggles - t0); end
    n_cmp++; if (lows !== 0) begin n_bad++; $display("FAIL b2b_busy_gap: got %0d low cycles want 0", lows); end
  endtask

  task automatic test_upload_drop();
    int t0, cyc;
    lat = 6;
    strobe(24'h000070);
    tick(2);
    ioctl_upload = 1'b0; t0 = toggles;
    tick(1);
    n_cmp++; if (busy_a !== 1'b1) begin n_bad++; $display("FAIL drain_busy: got %b want 1", busy_a); end
    wait_not_busy(40, cyc);
    n_cmp++; if (cyc !== 4) begin n_bad++; $display("FAIL drain_len: got %0d want 4", cyc); end
    n_cmp++; if (m_if.mem_req !== m_if.mem_ack) begin n_bad++; $display("FAIL drain_hs: got req %b want ack %b", m_if.mem_req, m_if.mem_ack); end
    strobe(24'h000010);
    n_cmp++; if (busy_a !== 1'b0) begin n_bad++; $display("FAIL noup_busy: got %b want 0", busy_a); end
    tick(2);
    n_cmp++; if (toggles - t0 !== 0) begin n_bad++; $display("FAIL drain_toggles: got %0d want 0", toggles - t0); end
    ioctl_upload = 1'b1; lat = 3;
    tick(2);
    strobe(24'h000010);
    wait_not_busy(40, cyc);
    n_cmp++; if (din_a !== 8'hEF) begin n_bad++; $display("FAIL reup_din: got %h want ef", din_a); end
    t0 = toggles;
    ioctl_upload = 1'b0;
    tick(2);
    n_cmp++; if (busy_a !== 1'b0) begin n_bad++; $display("FAIL idle_drop_busy: got %b want 0", busy_a); end
    ioctl_upload = 1'b1;
    tick(2);
    strobe(24'h000010);
    n_cmp++; if (busy_a !== 1'b1) begin n_bad++; $display("FAIL reup_miss: got %b want 1", busy_a); end
    wait_not_busy(40, cyc);
    n_cmp++; if (toggles - t0 !== 1) begin n_bad++; $display("FAIL reup_toggles: got %0d want 1", toggles - t0); end
    n_cmp++; if (din_a !== 8'hEF) begin n_bad++; $display("FAIL reup_din2: got %h want ef", din_a); end
  endtask

  task automatic test_reset_mid_fetch();
    int t0, cyc;
    lat = 20;
    strobe(24'h000090);
    tick(3);
    #3 reset_n = 1'b0;
    #1;
    n_cmp++; if (din_a !== 8'h00) begin n_bad++; $display("FAIL arst_din: got %h want 00", din_a); end
    n_cmp++; if (busy_a !== 1'b0) begin n_bad++; $display("FAIL arst_busy: got %b want 0", busy_a); end
    n_cmp++; if (m_if.mem_req !== 1'b0) begin n_bad++; $display("FAIL arst_req: got %b want 0", m_if.mem_req); end
    n_cmp++; if (m_if.mem_a !== 23'h0) begin n_bad++; $display("FAIL arst_mem_a: got %h want 0", m_if.mem_a); end
    @(posedge clk_sys); #3 reset_n = 1'b1;
    tick(2);
    t0 = toggles; lat = 5;
    strobe(24'h000010);
    n_cmp++; if (m_if.mem_req !== 1'b1) begin n_bad++; $display("FAIL arst_new_req: got %b want 1", m_if.mem_req); end
    n_cmp++; if (busy_a !== 1'b1) begin n_bad++; $display("FAIL arst_new_busy: got %b want 1", busy_a); end
    wait_not_busy(40, cyc);
    n_cmp++; if (din_a !== 8'hEF) begin n_bad++; $display("FAIL arst_new_din: got %h want ef", din_a); end
    n_cmp++; if (toggles - t0 !== 1) begin n_bad++; $display("FAIL arst_toggles: got %0d want 1", toggles - t0); end
    tick(8);
  endtask

`ifdef ROM_UPLOAD_PREFETCH_EN
  task automatic test_prefetch();
    logic [7:0] exp_b [8];
    int t0, highs;
    exp_b = '{8'h00, 8'hFF, 8'h01, 8'hFE, 8'h02, 8'hFD, 8'h03, 8'hFC};
    lat = 2; highs = 0;
    ioctl_upload = 1'b0; tick(2);
    ioctl_upload = 1'b1; tick(2);
    t0 = toggles;
    for (int i = 0; i < 8; i++) begin
      strobe(24'(i));
      if (i == 0) begin
        n_cmp++; if (busy_a !== 1'b1) begin n_bad++; $display("FAIL pf_first_busy: got %b want 1", busy_a); end
        tick(3);
        n_cmp++; if (din_a !== exp_b[0] || busy_a !== 1'b0) begin n_bad++; $display("FAIL pf_first_din: got %h/%b want %h/0", din_a, busy_a, exp_b[0]); end
      end else begin
        n_cmp++; if (din_a !== exp_b[i] || busy_a !== 1'b0) begin n_bad++; $display("FAIL pf_byte%0d: got %h/%b want %h/0", i, din_a, busy_a, exp_b[i]); end
        for (int k = 0; k < 3; k++) begin
          tick(1);
          if (busy_a) highs++;
        end
      end
    end
    tick(6);
    n_cmp++; if (highs !== 0) begin n_bad++; $display("FAIL pf_busy_seen: got %0d want 0", highs); end
    n_cmp++; if (toggles - t0 !== 5) begin n_bad++; $display("FAIL pf_toggles: got %0d want 5", toggles - t0); end
  endtask
`endif

  initial begin
    reset_n = 1'b0; ioctl_upload = 1'b0; ioctl_rd = 1'b0; ioctl_addr = '0;
    tick(3);
    reset_n = 1'b1;
    tick(1);
    test_reset();
    ioctl_upload = 1'b1;
    tick(2);
    test_miss_hit();
    test_base_wrap();
    test_back_to_back();
    test_upload_drop();
    test_reset_mid_fetch();
`ifdef ROM_UPLOAD_PREFETCH_EN
    test_prefetch();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/rom_upload_reader.md
Name: rom_upload_reader

Overview:
- Read-back counterpart of the ROM download path.
- Serves byte reads from the data_io upload side (ioctl_upload / ioctl_rd / ioctl_addr) by fetching 16-bit words from an sdram toggle-handshake port (req/ack, word address, 16-bit q).
- Lets the host dump loaded ROM or NVRAM regions back over SPI.
- Holds a one-word cache so that the two bytes of a word cost one SDRAM access.

Parameters:
- AW, 23, word address width of the SDRAM port; byte address is AW+1 bits.
- BASE, 0, word offset added to the host word address before it is driven on mem_a (modulo 2^AW).

Ports:
- clk_sys  in  1  system clock (48 MHz domain, same as the sdram controller).
- reset_n  in  1  asynchronous, active-low reset.
- ioctl_upload  in  1  upload session active.
- ioctl_rd  in  1  one-cycle strobe: host requests the byte at ioctl_addr.
- ioctl_addr  in  AW+1  byte address of the request; sampled with ioctl_rd.
- ioctl_din  out  8  requested byte; valid when busy=0 after a strobe.
- busy  out  1  high while a requested byte is not yet available.
- mem_req  out  1  toggle request to the sdram port.
- mem_ack  in  1  toggle acknowledge; the transaction completes when mem_ack == mem_req.
- mem_a  out  AW  word address = ioctl_addr[AW:1] + BASE.
- mem_q  in  16  read word, valid in the cycle mem_ack becomes equal to mem_req. Byte 0 = [7:0], byte 1 = [15:8].

Behaviour:
- Reset values:
  - ioctl_din=0, busy=0, mem_req=0, mem_a=0.
  - Cache invalid; no pending request; state IDLE.
  - The reset is asynchronous; all registers are cleared immediately.
- Cache: tag (AW bits), data (16 bits), valid flag. A hit requires valid=1 and ioctl_addr[AW:1]==tag.
- States: IDLE, FETCH, DRAIN (plus PREFETCH under the option).
- IDLE, on ioctl_rd & ioctl_upload:
  - Hit: ioctl_din <= the selected byte on the next edge (1-cycle latency); busy stays 0.
  - Miss: mem_a <= word address, mem_req toggles, busy <= 1, go to FETCH.
- FETCH, on mem_ack==mem_req:
  - Load the cache (tag, data, valid=1).
  - Drive ioctl_din with the byte selected by the latched addr[0]; busy <= 0.
  - Go to IDLE.
  - Miss latency is the SDRAM latency plus 1 cycle.
- A strobe while busy=1 goes to a one-deep pending slot that holds the address.
  - It is serviced right after the current completion, by the hit/miss rules, with busy held high throughout.
  - A further strobe while the slot is full overwrites the slot, so the last request wins.
- ioctl_rd with ioctl_upload=0 is ignored.
- ioctl_upload falling edge:
  - Cache valid cleared and pending slot dropped.
  - If a transaction is outstanding, go to DRAIN. DRAIN waits for mem_ack==mem_req, discards the data, then goes to IDLE; busy stays 1 in DRAIN.
  - Otherwise go to IDLE; busy <= 0.
  - A request is never issued while mem_req != mem_ack.
- ioctl_upload rising edge: cache invalidated, so stale data from a previous session is never served.
- Address wrap: mem_a = (ioctl_addr[AW:1] + BASE) mod 2^AW.
- mem_req toggles at most once per transaction and only from IDLE/PREFETCH-issue.

Optional Feature:
- Macro: ROM_UPLOAD_PREFETCH_EN.
- Defined:
  - After serving a byte with addr[0]=1 while the session is active and no request is pending, issue a fetch of word tag+1 in state PREFETCH.
  - busy stays 0 during PREFETCH.
  - On completion the cache is loaded with the new word.
  - A strobe that arrives during PREFETCH:
    - if it targets the prefetched word, it waits with busy=1 and completes with the prefetch;
    - otherwise it goes to the pending slot and is serviced after the prefetch.
  - Sequential dumps then see 1-cycle latency for every byte.
- Not defined: no speculative fetches; every miss costs a full SDRAM round trip.

Test Plan:
- Reset mid-FETCH (reset_n low while mem_req != mem_ack) -> ioctl_din=0, busy=0, mem_req=0 immediately; the next strobe issues a fresh request.
- Upload active; rd at addr 0x000010; the model returns 0xBEEF after 5 cycles -> mem_a=0x000008+BASE, one mem_req toggle, ioctl_din=0xEF, busy low 1 cycle after ack. Then rd at 0x000011 -> ioctl_din=0xBE next cycle, no toggle.
- BASE=0x7000; rd at 0x000002 -> mem_a=0x7001. rd at the top byte address 2^(AW+1)-1 with BASE=1 -> mem_a wraps to 0.
- Strobe at 0x20, then a second strobe at 0x40 while busy -> a second toggle only after the first ack; final ioctl_din = the byte of word 0x20; busy stays high between the two.
- ioctl_upload dropped while FETCH is outstanding; ack arrives 3 cycles later -> no new toggle; busy low after ack. A re-upload followed by rd at 0x10 misses (new toggle) despite the earlier cached word.
- With ROM_UPLOAD_PREFETCH_EN, sequential rd 0x00..0x07 at 4-cycle spacing, 2-cycle memory:
  - rd 0x00 is a miss with busy high;
  - every later byte is served 1 cycle after its strobe;
  - busy stays low for rd 0x01..0x07;
  - exactly 5 toggles occur: word 0 plus prefetches of words 1-4 (the last issued after byte 0x07).
